// File: rtl/ex_stage.sv
// Execute stage of the 32-bit MIPS pipeline: ALU, branch target and next-PC select, registered into EX/MEM.
// Optional EX_OVERFLOW_EN adds a registered signed-overflow flag for add/sub.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] sign_ext,
  input  logic [31:0] pc,
  input  logic        ALUSrc,
  input  logic [1:0]  ALUOp,
  input  logic [5:0]  funct,
  input  logic        branch,
  output logic [31:0] address,
  output logic        zero,
  output logic [31:0] resultOut,
  output logic [31:0] pcout,
  output logic [31:0] offset
`ifdef EX_OVERFLOW_EN
  ,output logic       overflow
`endif
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_res;
  logic        zero_c;
  logic [31:0] offset_c;
  logic [31:0] target_c;
  logic [31:0] next_pc_c;

  assign op_b  = ALUSrc ? sign_ext : rt;
  assign shamt = sign_ext[10:6];
  assign sum   = rs + op_b;
  assign diff  = rs - op_b;

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      OP_ADD: alu_res = sum;
      OP_SUB: alu_res = diff;
      OP_OR:  alu_res = rs | op_b;
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_res = sum;
          F_SUB, F_SUBU: alu_res = diff;
          F_AND:  alu_res = rs & op_b;
          F_OR:   alu_res = rs | op_b;
          F_XOR:  alu_res = rs ^ op_b;
          F_NOR:  alu_res = ~(rs | op_b);
          F_SLT:  alu_res = {31'b0, $signed(rs) < $signed(op_b)};
          F_SLTU: alu_res = {31'b0, rs < op_b};
          F_SLL:  alu_res = op_b << shamt;
          F_SRL:  alu_res = op_b >> shamt;
          F_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  assign zero_c    = (alu_res == 32'd0);
  assign offset_c  = {sign_ext[29:0], 2'b00};
  assign target_c  = pc + offset_c;
  assign next_pc_c = (branch && zero_c) ? target_c : pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address   <= '0;
      zero      <= 1'b0;
      resultOut <= '0;
      pcout     <= '0;
      offset    <= '0;
    end else begin
      address   <= target_c;
      zero      <= zero_c;
      resultOut <= alu_res;
      pcout     <= next_pc_c;
      offset    <= offset_c;
    end
  end

`ifdef EX_OVERFLOW_EN
  // Only the trapping forms (add/sub) flag overflow; the unsigned forms never do.
  logic is_add;
  logic is_sub;
  logic ovf_c;

  assign is_add = (ALUOp == OP_ADD) || ((ALUOp == OP_RTYPE) && (funct == F_ADD));
  assign is_sub = (ALUOp == OP_SUB) || ((ALUOp == OP_RTYPE) && (funct == F_SUB));

  always_comb begin
    ovf_c = 1'b0;
    if (is_add)
      ovf_c = (rs[31] == op_b[31]) && (sum[31] != rs[31]);
    else if (is_sub)
      ovf_c = (rs[31] != op_b[31]) && (diff[31] != rs[31]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else
      overflow <= ovf_c;
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected outputs are queued when inputs are driven and checked one edge later.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rs, rt, sign_ext, pc;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic        branch;
  logic [31:0] address, resultOut, pcout, offset;
  logic        zero;
`ifdef EX_OVERFLOW_EN
  logic        overflow;
`endif

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [31:0] addr;
    logic [31:0] npc;
    logic [31:0] off;
    logic        ovf;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  ex_stage dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .sign_ext(sign_ext), .pc(pc),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .funct(funct), .branch(branch),
    .address(address), .zero(zero), .resultOut(resultOut), .pcout(pcout), .offset(offset)
`ifdef EX_OVERFLOW_EN
    ,.overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".address"},   address,        32'd0);
    check({tag, ".zero"},      {31'b0, zero},  32'd0);
    check({tag, ".resultOut"}, resultOut,      32'd0);
    check({tag, ".pcout"},     pcout,          32'd0);
    check({tag, ".offset"},    offset,         32'd0);
`ifdef EX_OVERFLOW_EN
    check({tag, ".overflow"},  {31'b0, overflow}, 32'd0);
`endif
  endtask

  task automatic step(input string tag,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                      input logic [31:0] p, input logic src, input logic [1:0] op,
                      input logic [5:0] f, input logic br,
                      input logic [31:0] e_res, input logic e_zero, input logic [31:0] e_addr,
                      input logic [31:0] e_npc, input logic [31:0] e_off, input logic e_ovf);
    exp_t e;
    @(negedge clk);
    rs = a; rt = b; sign_ext = se; pc = p;
    ALUSrc = src; ALUOp = op; funct = f; branch = br;
    exp_q.push_back('{res: e_res, zero: e_zero, addr: e_addr, npc: e_npc, off: e_off,
                      ovf: e_ovf, tag: tag});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".resultOut"}, resultOut,     e.res);
    check({e.tag, ".zero"},      {31'b0, zero}, {31'b0, e.zero});
    check({e.tag, ".address"},   address,       e.addr);
    check({e.tag, ".pcout"},     pcout,         e.npc);
    check({e.tag, ".offset"},    offset,        e.off);
`ifdef EX_OVERFLOW_EN
    check({e.tag, ".overflow"},  {31'b0, overflow}, {31'b0, e.ovf});
`endif
  endtask

  initial begin
    reset = 1'b0;
    rs = 32'd5; rt = 32'd0; sign_ext = 32'd5; pc = 32'd4;
    ALUSrc = 1'b1; ALUOp = 2'b01; funct = 6'd0; branch = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    reset = 1'b1;

    //   tag          rs            rt            sign_ext      pc          src op    funct      br   res           z  addr          pcout         offset        ovf
    step("br_taken",  32'd5,        32'd0,        32'd5,        32'd4,      1, 2'b01, 6'b000000, 1, 32'd0,        1, 32'd24,       32'd24,       32'd20,       0);
    step("br_not",    32'd7,        32'd0,        32'd5,        32'd4,      1, 2'b01, 6'b000000, 1, 32'd2,        0, 32'd24,       32'd4,        32'd20,       0);
    step("r_add",     32'd6,        32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b100000, 0, 32'd9,        0, 32'h100,      32'h100,      32'd0,        0);
    step("r_sub",     32'd6,        32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b100010, 0, 32'd3,        0, 32'h100,      32'h100,      32'd0,        0);
    step("r_and",     32'd6,        32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b100100, 0, 32'd2,        0, 32'h100,      32'h100,      32'd0,        0);
    step("r_or",      32'd6,        32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b100101, 0, 32'd7,        0, 32'h100,      32'h100,      32'd0,        0);
    step("r_xor",     32'd6,        32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b100110, 0, 32'd5,        0, 32'h100,      32'h100,      32'd0,        0);
    step("r_nor",     32'd6,        32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b100111, 0, 32'hFFFFFFF8, 0, 32'h100,      32'h100,      32'd0,        0);
    step("r_slt0",    32'd6,        32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b101010, 0, 32'd0,        1, 32'h100,      32'h100,      32'd0,        0);
    step("r_slt1",    32'hFFFFFFFF, 32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b101010, 0, 32'd1,        0, 32'h100,      32'h100,      32'd0,        0);
    step("r_sltu",    32'hFFFFFFFF, 32'd3,        32'd0,        32'h100,    0, 2'b10, 6'b101011, 0, 32'd0,        1, 32'h100,      32'h100,      32'd0,        0);
    step("r_sll",     32'd0,        32'd1,        32'h100,      32'd0,      0, 2'b10, 6'b000000, 0, 32'd16,       0, 32'h400,      32'd0,        32'h400,      0);
    step("r_srl",     32'd0,        32'h80,       32'h100,      32'd0,      0, 2'b10, 6'b000010, 0, 32'd8,        0, 32'h400,      32'd0,        32'h400,      0);
    step("r_sra",     32'd0,        32'h80000000, 32'h100,      32'd0,      0, 2'b10, 6'b000011, 0, 32'hF8000000, 0, 32'h400,      32'd0,        32'h400,      0);
    step("r_unknown", 32'd6,        32'd3,        32'd0,        32'd8,      0, 2'b10, 6'b111111, 1, 32'd0,        1, 32'd8,        32'd8,        32'd0,        0);
    step("i_wrap",    32'd1,        32'd0,        32'hFFFFFFFF, 32'd0,      1, 2'b00, 6'b100010, 1, 32'd0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 0);
    step("i_or",      32'hF0,       32'd0,        32'h0F,       32'd0,      1, 2'b11, 6'b111111, 0, 32'hFF,       0, 32'h3C,       32'd0,        32'h3C,       0);
    step("br_zero_nb",32'd5,        32'd5,        32'd2,        32'h40,     0, 2'b01, 6'b000000, 0, 32'd0,        1, 32'h48,       32'h40,       32'd8,        0);
    step("add_ovf",   32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,      0, 2'b10, 6'b100000, 0, 32'h80000000, 0, 32'd0,        32'd0,        32'd0,        1);
    step("addu_novf", 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,      0, 2'b10, 6'b100001, 0, 32'h80000000, 0, 32'd0,        32'd0,        32'd0,        0);
    step("sub_ovf",   32'h80000000, 32'd0,        32'd1,        32'd0,      1, 2'b01, 6'b000000, 0, 32'h7FFFFFFF, 0, 32'd4,        32'd0,        32'd4,        1);
    step("load_pre",  32'd5,        32'd0,        32'd5,        32'd4,      1, 2'b00, 6'b000000, 1, 32'd10,       0, 32'd24,       32'd4,        32'd20,       0);

    // asynchronous reset mid-cycle, well before the next clock edge
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    step("post_reset",32'd5,        32'd0,        32'd5,        32'd4,      1, 2'b01, 6'b000000, 1, 32'd0,        1, 32'd24,       32'd24,       32'd20,       0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
